// File: rtl/gsquare_b_pkg.sv
// Shared definitions for the unary (stochastic) regeneration kernels.
package gsquare_b_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWarm,
        StRun
    } kern_state_e;

    function automatic int unsigned mid_scale(input int unsigned bw);
        return 32'd1 << (bw - 1);
    endfunction

endpackage

// File: rtl/unary_track_cnt.sv
// Saturating up/down tracking counter with a random-threshold comparator; regen is a
// bitstream whose density follows the density of in_bit.
module unary_track_cnt
    import gsquare_b_pkg::*;
#(
    parameter int unsigned BW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          in_bit,
    input  logic [BW-1:0] rand_num,
    output logic          regen
);

    logic [BW-1:0] cnt_q, cnt_d;

    assign regen = cnt_q > rand_num;

    // Step toward the input only when the regenerated bit disagrees with it.
    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            if (in_bit && !regen && cnt_q != '1) begin
                cnt_d = cnt_q + BW'(1);
            end else if (!in_bit && regen && cnt_q != '0) begin
                cnt_d = cnt_q - BW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= BW'(mid_scale(BW));
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/gsquare_b.sv
// Unary squaring kernel: out density = P(in)^2 by ANDing in with a regenerated copy.
// Define GSQUARE_B_ACC_EN to add the acc_out/acc_vld window decoder on the output stream.
module gsquare_b
    import gsquare_b_pkg::*;
#(
    parameter int unsigned BW       = 6,
    parameter int unsigned WARM_CYC = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [BW-1:0] randNum,
    input  logic          in,
    output logic          out,
    output logic          warm
`ifdef GSQUARE_B_ACC_EN
    ,
    output logic [BW:0]   acc_out,
    output logic          acc_vld
`endif
);

    kern_state_e   state_q, state_d;
    logic [BW-1:0] warm_cnt_q, warm_cnt_d;
    logic          out_q, out_d;
    logic          regen;

    unary_track_cnt #(
        .BW (BW)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .in_bit   (in),
        .rand_num (randNum),
        .regen    (regen)
    );

    always_comb begin
        state_d    = state_q;
        warm_cnt_d = warm_cnt_q;
        out_d      = 1'b0;
        if (en) begin
            unique case (state_q)
                StIdle: begin
                    warm_cnt_d = '0;
                    state_d    = (WARM_CYC == 0) ? StRun : StWarm;
                end
                StWarm: begin
                    if (warm_cnt_q == BW'(WARM_CYC - 1)) begin
                        state_d = StRun;
                    end else begin
                        warm_cnt_d = warm_cnt_q + BW'(1);
                    end
                end
                StRun:   out_d   = in & regen;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            warm_cnt_q <= '0;
            out_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            warm_cnt_q <= warm_cnt_d;
            out_q      <= out_d;
        end
    end

    assign out  = out_q;
    assign warm = (state_q == StWarm);

`ifdef GSQUARE_B_ACC_EN
    localparam int unsigned AW = BW + 1;

    logic [BW-1:0] win_q;
    logic [AW-1:0] acc_cnt_q;

    // Window advances only on enabled RUN cycles; the closing cycle's bit is included.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_q     <= '0;
            acc_cnt_q <= '0;
            acc_out   <= '0;
            acc_vld   <= 1'b0;
        end else begin
            acc_vld <= 1'b0;
            if (en && state_q == StRun) begin
                win_q <= win_q + BW'(1);
                if (win_q == '1) begin
                    acc_out   <= acc_cnt_q + AW'(out_d);
                    acc_cnt_q <= '0;
                    acc_vld   <= 1'b1;
                end else begin
                    acc_cnt_q <= acc_cnt_q + AW'(out_d);
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_gsquare_b.sv
// Self-checking bench for gsquare_b against a cycle-level behavioural model.
module tb_gsquare_b;
    import gsquare_b_pkg::*;

    localparam int unsigned BW       = 6;
    localparam int unsigned WARM_CYC = 16;
    localparam int          MAXV     = 63;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          in_bit;
    logic [BW-1:0] rand_num;
    logic          out_bit;
    logic          warm;
`ifdef GSQUARE_B_ACC_EN
    logic [BW:0]   acc_out;
    logic          acc_vld;
`endif

    int total = 0;
    int bad   = 0;

    // Model: counter value, number of enabled edges since reset, expected outputs.
    int m_cnt;
    int m_n;
    bit m_out;
    bit m_warm;

    always #5 clk = ~clk;

    gsquare_b #(
        .BW       (BW),
        .WARM_CYC (WARM_CYC)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .randNum (rand_num),
        .in      (in_bit),
        .out     (out_bit),
        .warm    (warm)
`ifdef GSQUARE_B_ACC_EN
        ,
        .acc_out (acc_out),
        .acc_vld (acc_vld)
`endif
    );

    // Drive one cycle, advance the model, then settle past the edge.
    task automatic step(input bit r, input bit e, input bit b, input int rn);
        bit regen;
        rst      = r;
        en       = e;
        in_bit   = b;
        rand_num = rn[BW-1:0];
        @(posedge clk);
        if (r) begin
            m_cnt = 32;
            m_n   = 0;
            m_out = 1'b0;
        end else if (e) begin
            regen = (m_cnt > rn);
            m_out = (m_n > int'(WARM_CYC)) && b && regen;
            if (b && !regen) m_cnt = (m_cnt < MAXV) ? m_cnt + 1 : MAXV;
            else if (!b && regen) m_cnt = (m_cnt > 0) ? m_cnt - 1 : 0;
            if (m_n < 100000) m_n++;
        end else begin
            m_out = 1'b0;
        end
        m_warm = (m_n >= 1) && (m_n <= int'(WARM_CYC));
        #1;
    endtask

    task automatic test_reset();
        step(1, 1, 1, 0);
        step(1, 0, 0, 0);
        total += 3;
        if (out_bit !== 1'b0) begin
            bad++;
            $display("FAIL reset out: got %0b want 0", out_bit);
        end
        if (warm !== 1'b0) begin
            bad++;
            $display("FAIL reset warm: got %0b want 0", warm);
        end
        if (dut.u_cnt.cnt_q !== 6'd32) begin
            bad++;
            $display("FAIL reset cnt: got %0d want 32", dut.u_cnt.cnt_q);
        end
    endtask

    task automatic test_sat_high();
        int ones = 0;
        step(1, 0, 0, 0);
        for (int i = 0; i < 1800; i++) begin
            step(0, 1, 1, int'($urandom_range(0, 63)));
            total++;
            if (out_bit !== m_out || warm !== m_warm) begin
                bad++;
                $display("FAIL sat_high cyc %0d: got out=%0b warm=%0b want out=%0b warm=%0b",
                         i, out_bit, warm, m_out, m_warm);
            end
            if (i >= 776 && out_bit === 1'b1) ones++;
        end
        total += 2;
        if (dut.u_cnt.cnt_q !== 6'd63) begin
            bad++;
            $display("FAIL sat_high cnt: got %0d want 63", dut.u_cnt.cnt_q);
        end
        if (ones <= 973) begin
            bad++;
            $display("FAIL sat_high density: got %0d/1024 want >973", ones);
        end
    endtask

    task automatic test_sat_low();
        step(1, 0, 0, 0);
        for (int i = 0; i < 1000; i++) begin
            step(0, 1, 0, int'($urandom_range(0, 63)));
            total += 2;
            if (out_bit !== 1'b0) begin
                bad++;
                $display("FAIL sat_low out cyc %0d: got %0b want 0", i, out_bit);
            end
            if (int'(dut.u_cnt.cnt_q) != m_cnt) begin
                bad++;
                $display("FAIL sat_low cnt cyc %0d: got %0d want %0d", i, dut.u_cnt.cnt_q, m_cnt);
            end
        end
        total++;
        if (dut.u_cnt.cnt_q !== 6'd0) begin
            bad++;
            $display("FAIL sat_low final cnt: got %0d want 0", dut.u_cnt.cnt_q);
        end
    endtask

    task automatic test_square(input int p_milli, input int exp_milli);
        int ones = 0;
        int dens;
        bit b;
        step(1, 0, 0, 0);
        for (int i = 0; i < 4196; i++) begin
            b = ($urandom_range(0, 999) < p_milli);
            step(0, 1, b, int'($urandom_range(0, 63)));
            total++;
            if (out_bit !== m_out) begin
                bad++;
                $display("FAIL square%0d out cyc %0d: got %0b want %0b", p_milli, i, out_bit, m_out);
            end
            if (i >= 100 && out_bit === 1'b1) ones++;
        end
        dens = ones * 1000 / 4096;
        total++;
        if (dens < exp_milli - 30 || dens > exp_milli + 30) begin
            bad++;
            $display("FAIL square%0d density: got %0d/1000 want %0d+-30", p_milli, dens, exp_milli);
        end
    endtask

    task automatic test_warmup();
        int warm_cycles = 0;
        int first_out   = -1;
        step(1, 0, 0, 0);
        for (int i = 0; i < 30; i++) begin
            step(0, 1, 1, 0);
            total += 2;
            if (warm !== (i < int'(WARM_CYC))) begin
                bad++;
                $display("FAIL warmup warm cyc %0d: got %0b want %0b", i, warm, i < int'(WARM_CYC));
            end
            if (out_bit !== m_out) begin
                bad++;
                $display("FAIL warmup out cyc %0d: got %0b want %0b", i, out_bit, m_out);
            end
            if (warm === 1'b1) warm_cycles++;
            if (out_bit === 1'b1 && first_out < 0) first_out = i;
        end
        total += 2;
        if (warm_cycles != int'(WARM_CYC)) begin
            bad++;
            $display("FAIL warmup length: got %0d want %0d", warm_cycles, WARM_CYC);
        end
        if (first_out != int'(WARM_CYC) + 1) begin
            bad++;
            $display("FAIL warmup first out: got %0d want %0d", first_out, WARM_CYC + 1);
        end
    endtask

    task automatic test_pause_and_reset();
        int snap;
        step(1, 0, 0, 0);
        for (int i = 0; i < 60; i++) step(0, 1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 63)));
        snap = int'(dut.u_cnt.cnt_q);
        total++;
        if (snap != m_cnt) begin
            bad++;
            $display("FAIL pause pre cnt: got %0d want %0d", snap, m_cnt);
        end
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 63)));
            total += 3;
            if (out_bit !== 1'b0) begin
                bad++;
                $display("FAIL pause out cyc %0d: got %0b want 0", i, out_bit);
            end
            if (int'(dut.u_cnt.cnt_q) != m_cnt) begin
                bad++;
                $display("FAIL pause cnt cyc %0d: got %0d want %0d", i, dut.u_cnt.cnt_q, m_cnt);
            end
            if (warm !== m_warm) begin
                bad++;
                $display("FAIL pause warm cyc %0d: got %0b want %0b", i, warm, m_warm);
            end
        end
        for (int i = 0; i < 40; i++) begin
            step(0, 1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 63)));
            total++;
            if (out_bit !== m_out || int'(dut.u_cnt.cnt_q) != m_cnt) begin
                bad++;
                $display("FAIL resume cyc %0d: got out=%0b cnt=%0d want out=%0b cnt=%0d",
                         i, out_bit, dut.u_cnt.cnt_q, m_out, m_cnt);
            end
        end
        step(1, 1, 1, 0);
        total += 4;
        if (dut.u_cnt.cnt_q !== 6'd32) begin
            bad++;
            $display("FAIL midrst cnt: got %0d want 32", dut.u_cnt.cnt_q);
        end
        if (dut.state_q !== StIdle) begin
            bad++;
            $display("FAIL midrst state: got %0d want %0d", dut.state_q, StIdle);
        end
        if (out_bit !== 1'b0) begin
            bad++;
            $display("FAIL midrst out: got %0b want 0", out_bit);
        end
        if (warm !== 1'b0) begin
            bad++;
            $display("FAIL midrst warm: got %0b want 0", warm);
        end
    endtask

    task automatic test_back_to_back();
        bit r;
        bit e;
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 199) == 0);
            e = ($urandom_range(0, 9) < 8);
            step(r, e, 1'($urandom_range(0, 1)), int'($urandom_range(0, 63)));
            total++;
            if (out_bit !== m_out || warm !== m_warm || int'(dut.u_cnt.cnt_q) != m_cnt) begin
                bad++;
                $display("FAIL random cyc %0d: got out=%0b warm=%0b cnt=%0d want %0b %0b %0d",
                         i, out_bit, warm, dut.u_cnt.cnt_q, m_out, m_warm, m_cnt);
            end
        end
    endtask

`ifdef GSQUARE_B_ACC_EN
    task automatic test_acc();
        int pulses = 0;
        int want_at;
        step(1, 0, 0, 0);
        want_at = int'(WARM_CYC) + 1 + 63;
        for (int i = 0; i < 220; i++) begin
            step(0, 1, 1, 0);
            if (acc_vld === 1'b1 || i == want_at) begin
                total += 2;
                if (acc_vld !== 1'b1 || i != want_at) begin
                    bad++;
                    $display("FAIL acc pulse: vld=%0b at %0d want pulse at %0d", acc_vld, i, want_at);
                end
                if (acc_out !== 7'd64) begin
                    bad++;
                    $display("FAIL acc value: got %0d want 64", acc_out);
                end
                if (acc_vld === 1'b1) pulses++;
                want_at += 64;
            end
        end
        total++;
        if (pulses != 3) begin
            bad++;
            $display("FAIL acc count: got %0d want 3", pulses);
        end
    endtask
`endif

    initial begin
        m_cnt  = 32;
        m_n    = 0;
        m_out  = 1'b0;
        m_warm = 1'b0;
        test_reset();
        test_sat_high();
        test_sat_low();
        test_square(500, 250);
        test_square(750, 563);
        test_warmup();
        test_pause_and_reset();
        test_back_to_back();
`ifdef GSQUARE_B_ACC_EN
        test_acc();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
